// File: rtl/ctr_seq.sv
// ctr_seq: command-driven sequencer for a WIDTH-bit up/down counter (one-shot, auto-reload, ping-pong).
// Optional tick prescaler is enabled by defining CTR_SEQ_PRESCALE_EN.
module ctr_seq #(
    parameter int WIDTH    = 10,
    parameter int PRESCALE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [1:0]       cfg_mode,
    input  logic [WIDTH-1:0] cfg_limit,
    input  logic             tick,
    output logic [WIDTH-1:0] count,
    output logic             count_dir,
    output logic             busy,
    output logic             tc_pulse,
    output logic             done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_PAUSE,
        S_DONE
    } state_t;

    localparam logic [1:0] OP_NOP   = 2'b00;
    localparam logic [1:0] OP_START = 2'b01;
    localparam logic [1:0] OP_STOP  = 2'b10;
    localparam logic [1:0] OP_PAUSE = 2'b11;

    localparam logic [1:0] M_UP  = 2'b00;
    localparam logic [1:0] M_DN  = 2'b01;
    localparam logic [1:0] M_RLD = 2'b10;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic [1:0]       mode_q, mode_d;
    logic             dir_q, dir_d;
    logic             tc_q, tc_d;
    logic             done_q, done_d;

    logic             accept;
    logic [1:0]       op;
    logic             step;
    logic [WIDTH-1:0] up_val, dn_val;

    // An unaccepted request behaves exactly like a NOP.
    assign accept = cmd_valid && (state_q != S_LOAD);
    assign op     = accept ? cmd_op : OP_NOP;

    // Saturating neighbours keep limit == 0 from wrapping.
    assign up_val = (count_q == limit_q) ? count_q : count_q + ONE;
    assign dn_val = (count_q == '0) ? count_q : count_q - ONE;

`ifdef CTR_SEQ_PRESCALE_EN
    localparam int            PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [PW-1:0] PRE_ONE  = PW'(1);

    logic [PW-1:0] pre_q, pre_d;

    always_comb begin
        pre_d = pre_q;
        if (op == OP_START || op == OP_STOP || state_q == S_LOAD) begin
            pre_d = '0;
        end else if (state_q == S_RUN && op == OP_NOP && tick) begin
            pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + PRE_ONE;
        end
    end

    assign step = (state_q == S_RUN) && (op == OP_NOP) && tick && (pre_q == PRE_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end
`else
    assign step = (state_q == S_RUN) && (op == OP_NOP) && tick;
`endif

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        dir_d   = dir_q;
        tc_d    = 1'b0;
        done_d  = done_q;
        mode_d  = mode_q;
        limit_d = limit_q;
        case (op)
            OP_START: begin
                mode_d  = cfg_mode;
                limit_d = cfg_limit;
                done_d  = 1'b0;
                state_d = S_LOAD;
            end
            OP_STOP: begin
                state_d = S_IDLE;
            end
            OP_PAUSE: begin
                if (state_q == S_RUN) begin
                    state_d = S_PAUSE;
                end else if (state_q == S_PAUSE) begin
                    state_d = S_RUN;
                end
            end
            default: begin
                if (state_q == S_LOAD) begin
                    count_d = (mode_q == M_DN) ? limit_q : '0;
                    dir_d   = (mode_q == M_DN);
                    state_d = S_RUN;
                end else if (step) begin
                    case (mode_q)
                        M_UP: begin
                            count_d = up_val;
                            if (up_val == limit_q) begin
                                tc_d    = 1'b1;
                                done_d  = 1'b1;
                                state_d = S_DONE;
                            end
                        end
                        M_DN: begin
                            count_d = dn_val;
                            if (dn_val == '0) begin
                                tc_d    = 1'b1;
                                done_d  = 1'b1;
                                state_d = S_DONE;
                            end
                        end
                        M_RLD: begin
                            if (count_q == limit_q) begin
                                count_d = '0;
                                tc_d    = 1'b1;
                            end else begin
                                count_d = count_q + ONE;
                            end
                        end
                        default: begin
                            // Ping-pong: the direction flips on the step that lands on an end.
                            if (!dir_q) begin
                                count_d = up_val;
                                if (up_val == limit_q) begin
                                    tc_d  = 1'b1;
                                    dir_d = 1'b1;
                                end
                            end else begin
                                count_d = dn_val;
                                if (dn_val == '0) begin
                                    tc_d  = 1'b1;
                                    dir_d = 1'b0;
                                end
                            end
                        end
                    endcase
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            count_q <= '0;
            dir_q   <= 1'b0;
            tc_q    <= 1'b0;
            done_q  <= 1'b0;
            mode_q  <= '0;
            limit_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            dir_q   <= dir_d;
            tc_q    <= tc_d;
            done_q  <= done_d;
            mode_q  <= mode_d;
            limit_q <= limit_d;
        end
    end

    assign cmd_ready = (state_q != S_LOAD);
    assign busy      = (state_q == S_LOAD) || (state_q == S_RUN) || (state_q == S_PAUSE);
    assign count     = count_q;
    assign count_dir = dir_q;
    assign tc_pulse  = tc_q;
    assign done      = done_q;

endmodule

// File: tb/tb_ctr_seq.sv
// Randomized and directed bench for ctr_seq; expected outputs come from a step-index model.
module tb_ctr_seq;

    localparam int WIDTH = 10;
`ifdef CTR_SEQ_PRESCALE_EN
    localparam int PRE = 4;
`else
    localparam int PRE = 1;
`endif

    localparam int P_IDLE  = 0;
    localparam int P_LOAD  = 1;
    localparam int P_RUN   = 2;
    localparam int P_PAUSE = 3;
    localparam int P_DONE  = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [1:0]       cfg_mode;
    logic [WIDTH-1:0] cfg_limit;
    logic             tick;
    logic [WIDTH-1:0] count;
    logic             count_dir;
    logic             busy;
    logic             tc_pulse;
    logic             done;

    ctr_seq #(.WIDTH(WIDTH), .PRESCALE(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_op    (cmd_op),
        .cfg_mode  (cfg_mode),
        .cfg_limit (cfg_limit),
        .tick      (tick),
        .count     (count),
        .count_dir (count_dir),
        .busy      (busy),
        .tc_pulse  (tc_pulse),
        .done      (done)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Model: the displayed count is a function of mode, limit and steps taken since LOAD.
    int ph, sh_mode, sh_lim, cur_mode, cur_lim, k, pre_cnt;
    bit done_m, tc_m;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, act, exp, $time);
    endtask

    function automatic bit is_term();
        case (cur_mode)
            0, 1:    return k == ((cur_lim > 0) ? cur_lim : 1);
            2:       return (k % (cur_lim + 1)) == 0;
            default: return (cur_lim == 0) || ((k % cur_lim) == 0);
        endcase
    endfunction

    function automatic int exp_count();
        int m, p;
        m = (k < cur_lim) ? k : cur_lim;
        case (cur_mode)
            0: return m;
            1: return cur_lim - m;
            2: return k % (cur_lim + 1);
            default: begin
                if (cur_lim == 0) return 0;
                p = k % (2 * cur_lim);
                return (p <= cur_lim) ? p : 2 * cur_lim - p;
            end
        endcase
    endfunction

    function automatic int exp_dir();
        case (cur_mode)
            0, 2: return 0;
            1:    return 1;
            default: begin
                if (k == 0) return 0;
                if (cur_lim == 0) return k % 2;
                return ((k % (2 * cur_lim)) >= cur_lim) ? 1 : 0;
            end
        endcase
    endfunction

    task automatic model_reset();
        ph = P_IDLE; sh_mode = 0; sh_lim = 0; cur_mode = 0; cur_lim = 0;
        k = 0; pre_cnt = 0; done_m = 0; tc_m = 0;
    endtask

    task automatic model_update(input bit r, input bit v, input int op, input int md,
                                input int lim, input bit tk);
        int eop;
        tc_m = 0;
        if (r) begin
            model_reset();
            return;
        end
        eop = (v && ph != P_LOAD) ? op : 0;
        if (eop == 1) begin
            sh_mode = md; sh_lim = lim; done_m = 0; ph = P_LOAD; pre_cnt = 0;
        end else if (eop == 2) begin
            ph = P_IDLE; pre_cnt = 0;
        end else if (eop == 3) begin
            if (ph == P_RUN) ph = P_PAUSE;
            else if (ph == P_PAUSE) ph = P_RUN;
        end else if (ph == P_LOAD) begin
            cur_mode = sh_mode; cur_lim = sh_lim; k = 0; pre_cnt = 0; ph = P_RUN;
        end else if (ph == P_RUN && tk) begin
            pre_cnt++;
            if (pre_cnt == PRE) begin
                pre_cnt = 0;
                k++;
                if (is_term()) begin
                    tc_m = 1;
                    if (cur_mode < 2) begin
                        done_m = 1;
                        ph = P_DONE;
                    end
                end
            end
        end
    endtask

    task automatic cyc(input bit r, input bit v, input int op, input int md,
                       input int lim, input bit tk);
        rst       = r;
        cmd_valid = v;
        cmd_op    = op[1:0];
        cfg_mode  = md[1:0];
        cfg_limit = lim[WIDTH-1:0];
        tick      = tk;
        @(posedge clk);
        model_update(r, v, op, md, lim, tk);
        @(negedge clk);
        chk("count",     int'(count),     exp_count());
        chk("count_dir", int'(count_dir), exp_dir());
        chk("busy",      int'(busy),      (ph == P_LOAD || ph == P_RUN || ph == P_PAUSE) ? 1 : 0);
        chk("cmd_ready", int'(cmd_ready), (ph != P_LOAD) ? 1 : 0);
        chk("tc_pulse",  int'(tc_pulse),  int'(tc_m));
        chk("done",      int'(done),      int'(done_m));
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 1);
    endtask

    task automatic start(input int md, input int lim, input bit tk);
        cyc(0, 1, 1, md, lim, tk);
    endtask

    initial begin
        model_reset();
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 1);
        ticks(10);

        start(0, 5, 1);
        ticks(5 * PRE + 4);

        start(2, 3, 1);
        ticks(10 * PRE);
        cyc(0, 1, 2, 0, 0, 1);
        ticks(3);

        start(3, 2, 1);
        ticks(10 * PRE);

        start(1, 4, 1);
        ticks(2 * PRE + 1);
        cyc(0, 1, 3, 0, 0, 1);
        ticks(5);
        cyc(0, 1, 3, 0, 0, 0);
        ticks(3 * PRE);

        start(0, 2, 0);
        ticks(5);
        cyc(1, 0, 0, 0, 0, 1);
        ticks(3);

        for (int m = 0; m < 4; m++) begin
            start(m, 0, 0);
            ticks(4 * PRE + 1);
        end

        // Config driven outside START must be ignored.
        start(2, 3, 0);
        for (int i = 0; i < 12; i++) cyc(0, 0, 1, 1, 7, 1);
        cyc(0, 1, 0, 3, 1, 1);

        for (int i = 0; i < 3000; i++) begin
            bit r, v, tk;
            int op, md, lim;
            r   = ($urandom_range(0, 299) == 0);
            v   = ($urandom_range(0, 5) == 0);
            op  = $urandom_range(0, 3);
            md  = $urandom_range(0, 3);
            lim = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 1023) : $urandom_range(0, 6);
            tk  = ($urandom_range(0, 3) != 0);
            cyc(r, v, op, md, lim, tk);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
